// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
//   Bundles the split core memory interfaces (instruction fetch, data read,
//   data write) together with the unified single-port RAM interface and the
//   sticky response-error flag.
//
//   slave  : the arbiter's view (takes requests, drives grants/RAM request)
//   master : the environment's view (core requesters and the RAM)
//
//   Fetch      : imem_ready/imem_addr in, imem_valid/imem_rresp/imem_rdata out
//   Data read  : dmem_rready/dmem_raddr in, dmem_rvalid/dmem_rresp/dmem_rdata out
//   Data write : dmem_wready/dmem_waddr/dmem_wdata/dmem_wstrb in, dmem_wvalid out
//   RAM        : mem_ready/mem_we/mem_addr/mem_wdata/mem_wstrb out,
//                mem_valid/mem_rresp/mem_rdata in
//   resp_err   : sticky flag, response seen with no outstanding read
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if;
  logic        imem_ready;
  logic        imem_valid;
  logic [31:0] imem_addr;
  logic        imem_rresp;
  logic [31:0] imem_rdata;

  logic        dmem_rready;
  logic        dmem_rvalid;
  logic [31:0] dmem_raddr;
  logic        dmem_rresp;
  logic [31:0] dmem_rdata;

  logic        dmem_wready;
  logic        dmem_wvalid;
  logic [31:0] dmem_waddr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;

  logic        mem_ready;
  logic        mem_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rresp;
  logic [31:0] mem_rdata;

  logic        resp_err;

  modport slave (
    input  imem_ready, imem_addr,
    output imem_valid, imem_rresp, imem_rdata,
    input  dmem_rready, dmem_raddr,
    output dmem_rvalid, dmem_rresp, dmem_rdata,
    input  dmem_wready, dmem_waddr, dmem_wdata, dmem_wstrb,
    output dmem_wvalid,
    output mem_ready, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_valid, mem_rresp, mem_rdata,
    output resp_err
  );

  modport master (
    output imem_ready, imem_addr,
    input  imem_valid, imem_rresp, imem_rdata,
    output dmem_rready, dmem_raddr,
    input  dmem_rvalid, dmem_rresp, dmem_rdata,
    output dmem_wready, dmem_waddr, dmem_wdata, dmem_wstrb,
    input  dmem_wvalid,
    input  mem_ready, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_valid, mem_rresp, mem_rdata,
    input  resp_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-port RAM between instruction fetch (I), data read (DR)
//   and data write (DW). One request is granted per cycle, fixed priority
//   DW > DR > I, except that a fetch refused for STARVE_LIMIT consecutive
//   cycles is promoted above both. Read responses return in order and are
//   steered back to their requester by a small tag FIFO.
//
//   Parameters:
//     MAX_OUTSTANDING : tag FIFO depth (outstanding reads), power of 2, >= 2
//     STARVE_LIMIT    : refused-fetch cycles before fetch is forced, >= 1
//   Ports:
//     clk    : clock
//     resetb : asynchronous active-low reset
//     bus    : request/grant/response signals (slave view)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned STARVE_LIMIT    = 8
) (
  input  logic               clk,
  input  logic               resetb,
  mem_port_arbiter_if.slave  bus
);

  localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [CNT_W-1:0] FIFO_DEPTH = CNT_W'(MAX_OUTSTANDING);
  localparam logic [STV_W-1:0] STV_MAX    = STV_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_I    = 2'd1,
    GNT_DR   = 2'd2,
    GNT_DW   = 2'd3
  } gnt_e;

  // Tag stored per outstanding read: 0 = fetch, 1 = data read.
  localparam logic TAG_I  = 1'b0;
  localparam logic TAG_DR = 1'b1;

  // State
  logic [MAX_OUTSTANDING-1:0] tags_q,     tags_d;
  logic [PTR_W-1:0]           wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0]           rd_ptr_q,   rd_ptr_d;
  logic [CNT_W-1:0]           cnt_q,      cnt_d;
  logic [STV_W-1:0]           starve_q,   starve_d;
  logic                       resp_err_q, resp_err_d;

  // Arbitration
  logic fifo_full;
  logic fifo_empty;
  logic elig_i;
  logic elig_dr;
  logic elig_dw;
  logic starved;
  gnt_e gnt;

  // Transfer / FIFO events
  logic xfer_i;
  logic push;
  logic pop;
  logic head_tag;

  always_comb begin
    fifo_full  = (cnt_q == FIFO_DEPTH);
    fifo_empty = (cnt_q == '0);
    // Full is judged on the registered count, so a same-cycle pop does not
    // free a slot for a new read.
    elig_dw    = bus.dmem_wready;
    elig_dr    = bus.dmem_rready && !fifo_full;
    elig_i     = bus.imem_ready  && !fifo_full;
    starved    = (starve_q >= STV_MAX);

    gnt = GNT_NONE;
    if (!resetb) begin
      gnt = GNT_NONE;
    end else if (elig_i && starved) begin
      gnt = GNT_I;
    end else if (elig_dw) begin
      gnt = GNT_DW;
    end else if (elig_dr) begin
      gnt = GNT_DR;
    end else if (elig_i) begin
      gnt = GNT_I;
    end
  end

  // Request mux, handshake outputs and response steering.
  always_comb begin
    bus.mem_ready   = 1'b0;
    bus.mem_we      = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_wdata   = '0;
    bus.mem_wstrb   = '0;
    bus.imem_valid  = 1'b0;
    bus.dmem_rvalid = 1'b0;
    bus.dmem_wvalid = 1'b0;

    unique case (gnt)
      GNT_DW: begin
        bus.mem_ready   = 1'b1;
        bus.mem_we      = 1'b1;
        bus.mem_addr    = bus.dmem_waddr;
        bus.mem_wdata   = bus.dmem_wdata;
        bus.mem_wstrb   = bus.dmem_wstrb;
        bus.dmem_wvalid = bus.mem_valid;
      end
      GNT_DR: begin
        bus.mem_ready   = 1'b1;
        bus.mem_addr    = bus.dmem_raddr;
        bus.dmem_rvalid = bus.mem_valid;
      end
      GNT_I: begin
        bus.mem_ready   = 1'b1;
        bus.mem_addr    = bus.imem_addr;
        bus.imem_valid  = bus.mem_valid;
      end
      default: begin
        bus.mem_ready   = 1'b0;
      end
    endcase

    xfer_i   = (gnt == GNT_I) && bus.mem_valid;
    push     = bus.mem_valid && ((gnt == GNT_I) || (gnt == GNT_DR));
    pop      = resetb && bus.mem_rresp && !fifo_empty;
    head_tag = tags_q[rd_ptr_q];

    bus.imem_rresp = pop && (head_tag == TAG_I);
    bus.dmem_rresp = pop && (head_tag == TAG_DR);
    bus.imem_rdata = bus.mem_rdata;
    bus.dmem_rdata = bus.mem_rdata;
    bus.resp_err   = resp_err_q;
  end

  // Next-state: tag FIFO, starvation counter, sticky error.
  always_comb begin
    tags_d     = tags_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    starve_d   = starve_q;
    resp_err_d = resp_err_q;

    if (push) begin
      tags_d[wr_ptr_q] = (gnt == GNT_DR) ? TAG_DR : TAG_I;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    // Counts every refused fetch cycle, including cycles with mem_valid low.
    if (!bus.imem_ready || xfer_i) begin
      starve_d = '0;
    end else if (starve_q != STV_MAX) begin
      starve_d = starve_q + STV_W'(1);
    end

    if (bus.mem_rresp && fifo_empty) begin
      resp_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      tags_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      starve_q   <= '0;
      resp_err_q <= 1'b0;
    end else begin
      tags_q     <= tags_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      starve_q   <= starve_d;
      resp_err_q <= resp_err_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed stimulus for mem_port_arbiter. Each issued cycle queues the
//   expected grant and/or read response; a negedge monitor pops and compares
//   whenever the DUT presents a transfer or a response.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic resetb;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(
    .MAX_OUTSTANDING(4),
    .STARVE_LIMIT   (8)
  ) dut (
    .clk   (clk),
    .resetb(resetb),
    .bus   (bus.slave)
  );

  typedef enum logic [1:0] {SRC_NONE = 2'd0, SRC_I = 2'd1, SRC_DR = 2'd2, SRC_DW = 2'd3} src_e;

  typedef struct {
    src_e        src;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } xfer_t;

  typedef struct {
    src_e        src;
    logic [31:0] data;
  } resp_t;

  xfer_t exp_xfer[$];
  resp_t exp_resp[$];

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_x(input src_e s, input logic [31:0] a, input logic we,
                        input logic [3:0] st, input logic [31:0] wd);
    xfer_t x;
    x.src = s; x.addr = a; x.we = we; x.wstrb = st; x.wdata = wd;
    exp_xfer.push_back(x);
  endtask

  task automatic push_r(input src_e s, input logic [31:0] d);
    resp_t r;
    r.src = s; r.data = d;
    exp_resp.push_back(r);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.imem_ready  = 1'b0;
    bus.imem_addr   = '0;
    bus.dmem_rready = 1'b0;
    bus.dmem_raddr  = '0;
    bus.dmem_wready = 1'b0;
    bus.dmem_waddr  = '0;
    bus.dmem_wdata  = '0;
    bus.dmem_wstrb  = '0;
    bus.mem_valid   = 1'b1;
    bus.mem_rresp   = 1'b0;
    bus.mem_rdata   = '0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_mem_ready"},  32'(bus.mem_ready),   32'd0);
    check({tag, "_imem_valid"}, 32'(bus.imem_valid),  32'd0);
    check({tag, "_dmem_rvalid"},32'(bus.dmem_rvalid), 32'd0);
    check({tag, "_dmem_wvalid"},32'(bus.dmem_wvalid), 32'd0);
    check({tag, "_imem_rresp"}, 32'(bus.imem_rresp),  32'd0);
    check({tag, "_dmem_rresp"}, 32'(bus.dmem_rresp),  32'd0);
    check({tag, "_mem_addr"},   bus.mem_addr,         32'd0);
    check({tag, "_mem_wstrb"},  32'(bus.mem_wstrb),   32'd0);
    check({tag, "_resp_err"},   32'(bus.resp_err),    32'd0);
  endtask

  // Monitor: compare every presented transfer and response with the queues.
  initial begin
    forever begin
      @(negedge clk);
      begin
        int   nv;
        src_e s;
        nv = int'(bus.imem_valid) + int'(bus.dmem_rvalid) + int'(bus.dmem_wvalid);
        if (nv > 1) begin
          n_cmp++; n_fail++;
          $display("FAIL xfer_onehot: got %0d valids, expected 1 (t=%0t)", nv, $time);
        end
        if (nv != 0) begin
          if (bus.dmem_wvalid)      s = SRC_DW;
          else if (bus.dmem_rvalid) s = SRC_DR;
          else                      s = SRC_I;
          if (exp_xfer.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL xfer_unexpected: got src %0d, expected none (t=%0t)", s, $time);
          end else begin
            xfer_t x;
            x = exp_xfer.pop_front();
            check("xfer_src",       32'(s),             32'(x.src));
            check("xfer_mem_ready", 32'(bus.mem_ready), 32'd1);
            check("xfer_addr",      bus.mem_addr,       x.addr);
            check("xfer_we",        32'(bus.mem_we),    32'(x.we));
            check("xfer_wstrb",     32'(bus.mem_wstrb), 32'(x.wstrb));
            if (x.we) check("xfer_wdata", bus.mem_wdata, x.wdata);
          end
        end
      end
      begin
        src_e        rs;
        logic [31:0] rd;
        if (bus.imem_rresp && bus.dmem_rresp) begin
          n_cmp++; n_fail++;
          $display("FAIL resp_onehot: got both rresp, expected one (t=%0t)", $time);
        end
        if (bus.imem_rresp || bus.dmem_rresp) begin
          rs = bus.dmem_rresp ? SRC_DR : SRC_I;
          rd = bus.dmem_rresp ? bus.dmem_rdata : bus.imem_rdata;
          if (exp_resp.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL resp_unexpected: got src %0d data 0x%08h, expected none (t=%0t)",
                     rs, rd, $time);
          end else begin
            resp_t r;
            r = exp_resp.pop_front();
            check("resp_src",  32'(rs), 32'(r.src));
            check("resp_data", rd,      r.data);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    resetb = 1'b0;

    // Reset state with every request asserted.
    bus.imem_ready  = 1'b1;
    bus.dmem_rready = 1'b1;
    bus.dmem_wready = 1'b1;
    bus.dmem_wstrb  = 4'hF;
    bus.imem_addr   = 32'h0000_0AA0;
    bus.mem_rresp   = 1'b1;
    repeat (2) step();
    check_quiet("reset");
    idle_inputs();
    step();
    resetb = 1'b1;
    step();

    // Single fetch, one-cycle memory latency.
    bus.imem_ready = 1'b1;
    bus.imem_addr  = 32'h0000_0100;
    push_x(SRC_I, 32'h0000_0100, 1'b0, 4'h0, '0);
    #1 check("t1_mem_we", 32'(bus.mem_we), 32'd0);
    step();
    bus.imem_ready = 1'b0;
    bus.mem_rresp  = 1'b1;
    bus.mem_rdata  = 32'h0000_0013;
    push_r(SRC_I, 32'h0000_0013);
    step();
    idle_inputs();
    step();

    // All three requesting: DW, then DR, then I.
    bus.dmem_wready = 1'b1;
    bus.dmem_waddr  = 32'h0000_2000;
    bus.dmem_wdata  = 32'hDEAD_BEEF;
    bus.dmem_wstrb  = 4'b0011;
    bus.dmem_rready = 1'b1;
    bus.dmem_raddr  = 32'h0000_3000;
    bus.imem_ready  = 1'b1;
    bus.imem_addr   = 32'h0000_0104;
    push_x(SRC_DW, 32'h0000_2000, 1'b1, 4'b0011, 32'hDEAD_BEEF);
    step();
    bus.dmem_wready = 1'b0;
    push_x(SRC_DR, 32'h0000_3000, 1'b0, 4'h0, '0);
    step();
    bus.dmem_rready = 1'b0;
    push_x(SRC_I, 32'h0000_0104, 1'b0, 4'h0, '0);
    step();
    bus.imem_ready = 1'b0;
    bus.mem_rresp  = 1'b1;
    bus.mem_rdata  = 32'h0000_0011;
    push_r(SRC_DR, 32'h0000_0011);
    step();
    bus.mem_rdata  = 32'h0000_0022;
    push_r(SRC_I, 32'h0000_0022);
    step();
    idle_inputs();
    step();

    // Starvation: fetch forced through on cycles 8 and 17 against a steady write.
    bus.imem_ready  = 1'b1;
    bus.imem_addr   = 32'h0000_0400;
    bus.dmem_wready = 1'b1;
    bus.dmem_waddr  = 32'h0000_2004;
    bus.dmem_wdata  = 32'h1234_5678;
    bus.dmem_wstrb  = 4'hF;
    for (int c = 0; c < 20; c++) begin
      if (c == 8 || c == 17) push_x(SRC_I, 32'h0000_0400, 1'b0, 4'h0, '0);
      else                   push_x(SRC_DW, 32'h0000_2004, 1'b1, 4'hF, 32'h1234_5678);
      step();
    end
    idle_inputs();
    bus.mem_rresp = 1'b1;
    bus.mem_rdata = 32'h0000_00B0;
    push_r(SRC_I, 32'h0000_00B0);
    step();
    bus.mem_rdata = 32'h0000_00B1;
    push_r(SRC_I, 32'h0000_00B1);
    step();
    idle_inputs();
    step();

    // FIFO full: four fetches accepted, fifth held off until after a pop.
    bus.imem_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      bus.imem_addr = 32'h0000_0200 + 32'(4 * c);
      push_x(SRC_I, 32'h0000_0200 + 32'(4 * c), 1'b0, 4'h0, '0);
      step();
    end
    bus.imem_addr = 32'h0000_0210;
    #1 check("full_refuse_valid", 32'(bus.imem_valid), 32'd0);
    check("full_refuse_ready", 32'(bus.mem_ready), 32'd0);
    step();
    bus.mem_rresp = 1'b1;
    bus.mem_rdata = 32'h0000_00C0;
    push_r(SRC_I, 32'h0000_00C0);
    #1 check("full_pop_refuse", 32'(bus.imem_valid), 32'd0);
    step();
    bus.mem_rdata = 32'h0000_00C1;
    push_r(SRC_I, 32'h0000_00C1);
    push_x(SRC_I, 32'h0000_0210, 1'b0, 4'h0, '0);
    step();
    bus.imem_ready = 1'b0;
    for (int c = 2; c < 5; c++) begin
      bus.mem_rdata = 32'h0000_00C0 + 32'(c);
      push_r(SRC_I, 32'h0000_00C0 + 32'(c));
      step();
    end
    idle_inputs();
    step();

    // Interleaved DR then I with two-cycle latency.
    bus.dmem_rready = 1'b1;
    bus.dmem_raddr  = 32'h0000_3000;
    push_x(SRC_DR, 32'h0000_3000, 1'b0, 4'h0, '0);
    step();
    bus.dmem_rready = 1'b0;
    bus.imem_ready  = 1'b1;
    bus.imem_addr   = 32'h0000_0104;
    push_x(SRC_I, 32'h0000_0104, 1'b0, 4'h0, '0);
    step();
    bus.imem_ready = 1'b0;
    bus.mem_rresp  = 1'b1;
    bus.mem_rdata  = 32'hAAAA_0000;
    push_r(SRC_DR, 32'hAAAA_0000);
    step();
    bus.mem_rdata  = 32'h5555_0000;
    push_r(SRC_I, 32'h5555_0000);
    step();
    idle_inputs();
    step();

    // Response with nothing outstanding: no rresp, sticky resp_err.
    check("err_before", 32'(bus.resp_err), 32'd0);
    bus.mem_rresp = 1'b1;
    bus.mem_rdata = 32'h0000_00EE;
    step();
    bus.mem_rresp = 1'b0;
    check("err_set", 32'(bus.resp_err), 32'd1);
    repeat (3) step();
    check("err_sticky", 32'(bus.resp_err), 32'd1);

    // Reset with two reads outstanding.
    bus.imem_ready = 1'b1;
    bus.imem_addr  = 32'h0000_0500;
    push_x(SRC_I, 32'h0000_0500, 1'b0, 4'h0, '0);
    step();
    bus.imem_ready  = 1'b0;
    bus.dmem_rready = 1'b1;
    bus.dmem_raddr  = 32'h0000_3008;
    push_x(SRC_DR, 32'h0000_3008, 1'b0, 4'h0, '0);
    step();
    bus.imem_ready  = 1'b1;
    bus.dmem_wready = 1'b1;
    bus.dmem_wstrb  = 4'hF;
    bus.mem_rresp   = 1'b1;
    resetb          = 1'b0;
    #1 check_quiet("midrst");
    step();
    idle_inputs();
    resetb = 1'b1;
    step();
    check("post_rst_err", 32'(bus.resp_err), 32'd0);
    bus.mem_rresp = 1'b1;
    bus.mem_rdata = 32'h0000_0077;
    #1 check("post_rst_irresp", 32'(bus.imem_rresp), 32'd0);
    check("post_rst_drresp", 32'(bus.dmem_rresp), 32'd0);
    step();
    bus.mem_rresp = 1'b0;
    check("post_rst_err_set", 32'(bus.resp_err), 32'd1);
    step();

    check("left_xfer", 32'(exp_xfer.size()), 32'd0);
    check("left_resp", 32'(exp_resp.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port memory between the core's three memory requesters:
  - instruction fetch (I)
  - data read (DR)
  - data write (DW)
- Sits between the core's split imem/dmem interfaces and a single unified RAM, in the single-RAM build.
- Grants one request per cycle using fixed priority plus an anti-starvation override for fetch.
- Routes in-order read responses back to the originating requester through a tag FIFO.

Parameters:
- MAX_OUTSTANDING, 4: depth of the read-tag FIFO (outstanding reads); power of 2, ≥2.
- STARVE_LIMIT, 8: consecutive cycles a pending fetch may be refused before it is forced to top priority; ≥1.

Ports:
- clk  in  1  clock
- resetb  in  1  reset
- imem_ready  in  1  fetch request
- imem_valid  out  1  fetch accepted this cycle
- imem_addr  in  32  fetch byte address
- imem_rresp  out  1  fetch data valid
- imem_rdata  out  32  fetch data
- dmem_rready  in  1  data read request
- dmem_rvalid  out  1  data read accepted
- dmem_raddr  in  32  data read address
- dmem_rresp  out  1  data read data valid
- dmem_rdata  out  32  data read data
- dmem_wready  in  1  data write request
- dmem_wvalid  out  1  data write accepted
- dmem_waddr  in  32  write address
- dmem_wdata  in  32  write data
- dmem_wstrb  in  4  byte strobes
- mem_ready  out  1  unified request
- mem_valid  in  1  memory can accept
- mem_we  out  1  request is a write
- mem_addr  out  32  unified address
- mem_wdata  out  32  write data
- mem_wstrb  out  4  strobes (0 on reads)
- mem_rresp  in  1  read data valid (in order)
- mem_rdata  in  32  read data
- resp_err  out  1  sticky: response arrived with no outstanding read

Behaviour:
- Reset: clk is the clock. resetb is the reset: asynchronous, active-low. Reset clears tag FIFO (empty), starvation counter = 0, resp_err = 0.
  - All request/response outputs are 0 during reset; mem_addr/mem_wdata = 0, mem_wstrb = 0.
- Transfer: a requester transfers when its *_ready and *_valid are both high in the same cycle.
  - *_valid is combinational from the grant and mem_valid.
  - Zero added latency: mem_ready equals the OR of eligible requests.
- Eligibility:
  - DW is eligible if dmem_wready.
  - DR is eligible if dmem_rready and FIFO not full.
  - I is eligible if imem_ready and FIFO not full.
  - Full blocks reads even if a pop occurs in the same cycle.
- Priority (normal): DW > DR > I. The older write-back-stage store precedes the younger load.
- Starvation override: when starve_cnt ≥ STARVE_LIMIT and I is eligible, I wins over both.
- Starvation counter:
  - Increments (saturating) each cycle imem_ready=1 and I is not transferred.
  - Clears on an I transfer or when imem_ready=0.
- Mux: the granted requester drives mem_addr/mem_we/mem_wdata/mem_wstrb.
  - When no request is eligible: mem_ready=0, mem_we=0, mem_wstrb=0.
- Tag FIFO:
  - On a read transfer (I or DR accepted with mem_valid=1), push tag (0=I, 1=DR).
  - On mem_rresp, pop the head and route mem_rdata combinationally to imem_rdata/dmem_rdata. Assert the matching *_rresp the same cycle.
  - Both rdata outputs always carry mem_rdata; only rresp is steered.
- Simultaneous push and pop are allowed when not full.
- Pointers wrap modulo MAX_OUTSTANDING; count width is $clog2(MAX_OUTSTANDING)+1.
- mem_rresp with FIFO empty: no rresp output, set resp_err (cleared only by reset).
- mem_valid=0: no transfers, no pushes. The starvation counter still counts refused fetch cycles.
- Reset mid-operation: outstanding tags are discarded; responses arriving after reset raise resp_err.

Test Plan:
- Only imem_ready=1, addr 0x100, mem_valid=1, memory responds 1 cycle later with 0x00000013 -> imem_valid=1 in cycle 0, mem_we=0; imem_rresp=1 with imem_rdata=0x00000013 in cycle 1; dmem_rresp=0.
- dmem_wready, dmem_rready and imem_ready all high, waddr 0x2000, wstrb 4'b0011 -> cycle 0 grants DW (mem_we=1, mem_wstrb=0011), then DR, then I; no rresp is generated for the write.
- imem_ready held high with dmem_wready held high for 20 cycles -> imem_valid first asserts on cycle 8 (STARVE_LIMIT), the counter clears, and DW resumes winning on cycle 9.
- mem_rresp held low and 5 back-to-back fetch requests -> 4 accepted, 5th refused (imem_valid=0) until the first mem_rresp pops; responses return in order with tags I,I,I,I.
- Interleave DR (0x3000) and I (0x104) transfers with 2-cycle memory latency, data 0xAAAA0000 then 0x55550000 -> dmem_rresp gets 0xAAAA0000, then imem_rresp gets 0x55550000.
- mem_rresp pulse with FIFO empty -> no *_rresp, resp_err=1 and stays 1; assert resetb=0 mid-burst with 2 outstanding -> FIFO empty, resp_err=0, all valids 0.
